// File: rtl/s2c_pkg.sv
// Shared types and sizing for the C-to-RTL stream bridge.
// DATA_SIZE follows the fetch array size; fallback is only for standalone builds.
`ifndef S2CIF_DATA_SIZE
`define S2CIF_DATA_SIZE 16
`endif

package s2c_pkg;
  localparam int DATA_SIZE = `S2CIF_DATA_SIZE;
  localparam int WORD_W    = 32;

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_e;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_RET = 2'd1, ERR_LEN = 2'd2} err_e;
endpackage

// File: rtl/s2c_word_buf.sv
// DATA_SIZE x WORD_W register file: whole-packet parallel load, one indexed read.
module s2c_word_buf #(
  parameter int DATA_SIZE = 16,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(DATA_SIZE+1)
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [DATA_SIZE*WORD_W-1:0] wdata,
  input  logic [CNT_W-1:0]            raddr,
  output logic [WORD_W-1:0]           rdata
);
  localparam int AW = $clog2(DATA_SIZE);

  logic [WORD_W-1:0] mem [DATA_SIZE];

  // Contents are don't-care until loaded, so no reset on the storage.
  for (genvar i = 0; i < DATA_SIZE; i++) begin : g_word
    always_ff @(posedge clk)
      if (we) mem[i] <= wdata[i*WORD_W +: WORD_W];
  end

  // The top never presents an index beyond len-1 < DATA_SIZE.
  assign rdata = mem[raddr[AW-1:0]];
endmodule

// File: rtl/s2c_stream_bridge.sv
// Latches one C-side fetch and streams its words over valid/ready,
// reporting completion (done) and rejected fetches (err/err_code).
module s2c_stream_bridge import s2c_pkg::*; #(
  parameter int DATA_SIZE = s2c_pkg::DATA_SIZE,
  parameter int WORD_W    = s2c_pkg::WORD_W,
  parameter int CNT_W     = $clog2(DATA_SIZE+1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [31:0]                 ld_ret,
  input  logic [CNT_W-1:0]            ld_len,
  input  logic [DATA_SIZE*WORD_W-1:0] ld_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic [CNT_W-1:0]            out_idx,
  output logic                        out_last,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_code,
  output logic [31:0]                 last_ret
);
  state_e            state, state_d;
  err_e              code_q, code_d;
  logic [CNT_W-1:0]  len_q, len_d, idx_q, idx_d;
  logic [31:0]       ret_q, ret_d;
  logic              done_q, done_d, err_q, err_d;
  logic              buf_we;
  logic [WORD_W-1:0] rd_word;

  s2c_word_buf #(.DATA_SIZE(DATA_SIZE), .WORD_W(WORD_W), .CNT_W(CNT_W)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .wdata (ld_data),
    .raddr (idx_q),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      code_q <= ERR_NONE;
      len_q  <= '0;
      idx_q  <= '0;
      ret_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      code_q <= code_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      ret_q  <= ret_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    code_d  = code_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ret_d   = ret_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    buf_we  = 1'b0;
    case (state)
      IDLE: if (ld_valid) begin
        ret_d = ld_ret;
        // A bad ret code outranks a bad length.
        if (ld_ret != '0) begin
          err_d  = 1'b1;
          code_d = ERR_RET;
        end else if (ld_len > CNT_W'(DATA_SIZE)) begin
          err_d  = 1'b1;
          code_d = ERR_LEN;
        end else if (ld_len == '0) begin
          done_d = 1'b1;
          code_d = ERR_NONE;
        end else begin
          code_d  = ERR_NONE;
          buf_we  = 1'b1;
          len_d   = ld_len;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: if (out_ready) begin
        if (out_last) state_d = FIN;
        else          idx_d   = idx_q + CNT_W'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ld_ready  = (state == IDLE);
  assign out_valid = (state == STREAM);
  assign out_last  = out_valid && (idx_q == len_q - CNT_W'(1));
  assign out_data  = out_valid ? rd_word : '0;
  assign out_idx   = idx_q;
  assign done      = done_q | (state == FIN);
  assign err       = err_q;
  assign err_code  = code_q;
  assign last_ret  = ret_q;

  // A stalled word must not change under the consumer.
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> $stable(out_data) && $stable(out_idx) && $stable(out_last));
endmodule

// File: doc/s2c_stream_bridge.md
Name: s2c_stream_bridge

Overview:
- Clocked consumer of one C-side data fetch: ret code, word count and `S2CIF_DATA_SIZE`-word array.
- Latches the fetch into a local buffer and streams the words one per beat to RTL over valid/ready.
- Sits directly downstream of the testbench fetch path: the bench calls get_data, then presents the result to this block.
- Delivers C-model data to the DUT with cycle-accurate backpressure; reports completion and errors.

Parameters:
- DATA_SIZE, `S2CIF_DATA_SIZE (16), buffer depth in words; must equal the fetch array size.
- WORD_W, 32, width of one data word (unsigned int).
- CNT_W, $clog2(DATA_SIZE+1), width of length and index fields.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ld_valid  in  1  fetch result presented
- ld_ready  out  1  bridge can accept a fetch (IDLE)
- ld_ret  in  32  ret code from fetch; 0 = success
- ld_len  in  CNT_W  number of valid words, 0..DATA_SIZE
- ld_data  in  DATA_SIZE*WORD_W  packed array; word i at bits [i*WORD_W +: WORD_W]
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accepts word
- out_data  out  WORD_W  current word
- out_idx  out  CNT_W  index of current word
- out_last  out  1  current word is final word of packet
- done  out  1  one-cycle pulse: packet fully consumed or empty packet accepted
- err  out  1  one-cycle pulse: packet rejected
- err_code  out  2  0 none, 1 ret!=0, 2 len>DATA_SIZE; held until next accepted load
- last_ret  out  32  ret of last accepted load; held

Behaviour:
- Reset (async assert, sync release): state IDLE, ld_ready=1, out_valid=0, out_last=0, done=0, err=0, err_code=0, last_ret=0, out_idx=0, out_data=0, buffer contents don't-care.
- FSM states: IDLE, STREAM, FIN.
- Load in IDLE: a load fires when ld_valid && ld_ready. Same edge: last_ret<=ld_ret; err_code updated.
  - ld_ret!=0: err pulse next cycle, err_code=1, no stream; stays IDLE.
  - Else ld_len>DATA_SIZE: err pulse, err_code=2, no stream; stays IDLE. ret check takes priority.
  - Else ld_len==0: done pulse next cycle, err_code=0; stays IDLE.
  - Else: buffer<=ld_data, len<=ld_len, idx<=0, err_code=0, go STREAM.
- STREAM:
  - Timing: out_valid=1 from the cycle after the load (1-cycle latency). out_data=buf[idx], out_idx=idx, out_last=(idx==len-1).
  - ld_ready=0 throughout STREAM.
  - Beat fires on out_valid && out_ready; idx increments.
  - Last beat: go FIN.
  - Without out_ready, all outputs hold stable (AXI-style; valid never withdrawn).
- FIN: one cycle; done=1, out_valid=0, ld_ready=0; then IDLE.
  - Back-to-back min spacing: load, len cycles, FIN, IDLE.
- ld_data sampling: read only on the load edge; later changes are ignored.
- Back-to-back IDLE loads: accepted every cycle for err/empty packets; each yields its own pulse.
- Reset mid-STREAM: immediate abort, outputs to reset values, no done/err pulse.
- Index counter never exceeds len-1; no wrap.
- Full packet (len==DATA_SIZE): last word index DATA_SIZE-1, out_last set there.
- Assertion: out_valid && !out_ready implies stable out_data/out_idx/out_last next cycle.

Decomposition:
- Shared package s2c_pkg holds:
  - state enum {IDLE, STREAM, FIN};
  - err_code enum {ERR_NONE=0, ERR_RET=1, ERR_LEN=2};
  - localparam WORD_W=32;
  - the DATA_SIZE default tied to `S2CIF_DATA_SIZE from macro.svh.
- Sub-module s2c_word_buf: DATA_SIZE x WORD_W register file with parallel load and indexed read port. The FSM and counters stay in the top.

Test Plan:
- Reset, then load ret=0 len=3 data={0xA,0xB,0xC}, out_ready=1 -> beats on 3 consecutive cycles starting 1 cycle after load: 0xA/idx0, 0xB/idx1, 0xC/idx2 with out_last; done pulse next cycle; ld_ready=1 cycle after.
- len=4, out_ready toggling 1,0,0,1,1,0,1 -> data/idx stable during stalls; 4 beats total in order; one done pulse.
- ld_ret=5 -> err pulse, err_code=1, last_ret=5, no out_valid. Then ret=0 len=17 (DATA_SIZE=16) -> err_code=2, no stream. Then ret=3 len=20 -> err_code=1.
- ld_len=0, ret=0 -> done pulse 1 cycle after load, no out_valid. len=16 full buffer -> 16 beats, out_last on idx 15.
- rst_n asserted asynchronously during beat 2 of len=8 -> out_valid drops without a clock edge, no done. After release, ld_ready=1 and a new len=2 packet streams correctly.
- Two valid packets presented back-to-back with ld_valid held high -> second accepted only on the cycle after FIN; both fully streamed; two done pulses.
